// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: decodes a MIPS instruction, drives the
// ALU operands for EXEC_CYCLES cycles, then returns result, flags and branch decision.
module alu_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_funct,
    input  logic [DATA_W-1:0] req_rs_val,
    input  logic [DATA_W-1:0] req_rt_val,
    input  logic [15:0]       req_imm,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_lt,
    input  logic              alu_gt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_lt,
    output logic              rsp_gt,
    output logic              rsp_taken,
    output logic              rsp_illegal
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0101;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [3:0]        r_op;
    logic              r_is_beq;
    logic              r_is_bne;
    logic              r_illegal;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_lt;
    logic              r_rsp_gt;
    logic              r_rsp_taken;
    logic              r_rsp_illegal;

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_data2;
    logic              w_is_beq;
    logic              w_is_bne;
    logic              w_illegal;
    logic [DATA_W-1:0] w_imm_sx;
    logic [DATA_W-1:0] w_imm_zx;
    logic              w_accept;
    logic              w_capture;
    logic              w_equal;

    assign w_imm_sx = {{(DATA_W-16){req_imm[15]}}, req_imm};
    assign w_imm_zx = {{(DATA_W-16){1'b0}}, req_imm};

    // Unknown encodings still execute as ADD on rs/rt, but are flagged.
    always_comb begin
        w_op      = OP_ADD;
        w_data2   = req_rt_val;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_illegal = 1'b0;
        case (req_opcode)
            6'b000000: begin
                case (req_funct)
                    6'b100000: w_op = OP_ADD;
                    6'b100010: w_op = OP_SUB;
                    6'b100100: w_op = OP_AND;
                    6'b100101: w_op = OP_OR;
                    6'b101010: w_op = OP_SLT;
                    default:   w_illegal = 1'b1;
                endcase
            end
            6'b001000: w_data2 = w_imm_sx;
            6'b001010: begin
                w_op    = OP_SLT;
                w_data2 = w_imm_sx;
            end
            6'b001100: begin
                w_op    = OP_AND;
                w_data2 = w_imm_zx;
            end
            6'b001101: begin
                w_op    = OP_OR;
                w_data2 = w_imm_zx;
            end
            6'b100011, 6'b101011: w_data2 = w_imm_sx;
            6'b000100: begin
                w_op     = OP_SUB;
                w_is_beq = 1'b1;
            end
            6'b000101: begin
                w_op     = OP_SUB;
                w_is_bne = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = ST_EXEC;
            ST_EXEC: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_capture = (r_state == ST_EXEC) && (r_cnt == 4'd0);
    // The ALU keeps stale lt/gt on equal operands, so equality overrides them.
    assign w_equal   = (r_data1 == r_data2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_data1       <= '0;
            r_data2       <= '0;
            r_op          <= '0;
            r_is_beq      <= 1'b0;
            r_is_bne      <= 1'b0;
            r_illegal     <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_lt      <= 1'b0;
            r_rsp_gt      <= 1'b0;
            r_rsp_taken   <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt     <= CNT_INIT;
                r_data1   <= req_rs_val;
                r_data2   <= w_data2;
                r_op      <= w_op;
                r_is_beq  <= w_is_beq;
                r_is_bne  <= w_is_bne;
                r_illegal <= w_illegal;
            end
            if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result  <= alu_result;
                r_rsp_zero    <= alu_zero;
                r_rsp_lt      <= alu_lt && !w_equal;
                r_rsp_gt      <= alu_gt && !w_equal;
                r_rsp_taken   <= (r_is_beq && alu_zero) || (r_is_bne && !alu_zero);
                r_rsp_illegal <= r_illegal;
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign alu_data1   = r_data1;
    assign alu_data2   = r_data2;
    assign alu_op      = r_op;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_lt      = r_rsp_lt;
    assign rsp_gt      = r_rsp_gt;
    assign rsp_taken   = r_rsp_taken;
    assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (EXEC_CYCLES=1 and 3) sharing a clock,
// each driving a behavioural ALU whose lt/gt hold their last value on equal operands.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [15:0] req_imm;

    logic sel;
    logic m_req_valid;
    logic m_rsp_ready;

    logic        d0_req_valid, d0_req_ready, d0_rsp_valid, d0_rsp_ready;
    logic [31:0] d0_alu_data1, d0_alu_data2, d0_alu_result, d0_rsp_result;
    logic [3:0]  d0_alu_op;
    logic        d0_alu_zero, d0_alu_lt, d0_alu_gt;
    logic        d0_rsp_zero, d0_rsp_lt, d0_rsp_gt, d0_rsp_taken, d0_rsp_illegal;

    logic        d1_req_valid, d1_req_ready, d1_rsp_valid, d1_rsp_ready;
    logic [31:0] d1_alu_data1, d1_alu_data2, d1_alu_result, d1_rsp_result;
    logic [3:0]  d1_alu_op;
    logic        d1_alu_zero, d1_alu_lt, d1_alu_gt;
    logic        d1_rsp_zero, d1_rsp_lt, d1_rsp_gt, d1_rsp_taken, d1_rsp_illegal;

    alu_issue_ctrl #(.DATA_W(32), .EXEC_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val), .req_imm(req_imm),
        .alu_data1(d0_alu_data1), .alu_data2(d0_alu_data2), .alu_op(d0_alu_op),
        .alu_result(d0_alu_result), .alu_zero(d0_alu_zero),
        .alu_lt(d0_alu_lt), .alu_gt(d0_alu_gt),
        .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
        .rsp_result(d0_rsp_result), .rsp_zero(d0_rsp_zero),
        .rsp_lt(d0_rsp_lt), .rsp_gt(d0_rsp_gt),
        .rsp_taken(d0_rsp_taken), .rsp_illegal(d0_rsp_illegal)
    );

    alu_issue_ctrl #(.DATA_W(32), .EXEC_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(d1_req_valid), .req_ready(d1_req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val), .req_imm(req_imm),
        .alu_data1(d1_alu_data1), .alu_data2(d1_alu_data2), .alu_op(d1_alu_op),
        .alu_result(d1_alu_result), .alu_zero(d1_alu_zero),
        .alu_lt(d1_alu_lt), .alu_gt(d1_alu_gt),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready),
        .rsp_result(d1_rsp_result), .rsp_zero(d1_rsp_zero),
        .rsp_lt(d1_rsp_lt), .rsp_gt(d1_rsp_gt),
        .rsp_taken(d1_rsp_taken), .rsp_illegal(d1_rsp_illegal)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd5:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    logic st0_lt = 1'b0, st0_gt = 1'b0, st1_lt = 1'b0, st1_gt = 1'b0;
    always @(posedge clk) begin
        if (d0_alu_data1 != d0_alu_data2) begin
            st0_lt <= d0_alu_data1 < d0_alu_data2;
            st0_gt <= d0_alu_data1 > d0_alu_data2;
        end
        if (d1_alu_data1 != d1_alu_data2) begin
            st1_lt <= d1_alu_data1 < d1_alu_data2;
            st1_gt <= d1_alu_data1 > d1_alu_data2;
        end
    end

    assign d0_alu_result = alu_fn(d0_alu_data1, d0_alu_data2, d0_alu_op);
    assign d0_alu_zero   = (d0_alu_result == 32'd0);
    assign d0_alu_lt     = (d0_alu_data1 == d0_alu_data2) ? st0_lt : (d0_alu_data1 < d0_alu_data2);
    assign d0_alu_gt     = (d0_alu_data1 == d0_alu_data2) ? st0_gt : (d0_alu_data1 > d0_alu_data2);
    assign d1_alu_result = alu_fn(d1_alu_data1, d1_alu_data2, d1_alu_op);
    assign d1_alu_zero   = (d1_alu_result == 32'd0);
    assign d1_alu_lt     = (d1_alu_data1 == d1_alu_data2) ? st1_lt : (d1_alu_data1 < d1_alu_data2);
    assign d1_alu_gt     = (d1_alu_data1 == d1_alu_data2) ? st1_gt : (d1_alu_data1 > d1_alu_data2);

    assign d0_req_valid = m_req_valid && !sel;
    assign d1_req_valid = m_req_valid && sel;
    assign d0_rsp_ready = m_rsp_ready && !sel;
    assign d1_rsp_ready = m_rsp_ready && sel;

    logic        m_req_ready, m_rsp_valid;
    logic [31:0] m_alu_data1, m_alu_data2, m_rsp_result;
    logic [3:0]  m_alu_op;
    logic        m_rsp_zero, m_rsp_lt, m_rsp_gt, m_rsp_taken, m_rsp_illegal;
    assign m_req_ready   = sel ? d1_req_ready   : d0_req_ready;
    assign m_rsp_valid   = sel ? d1_rsp_valid   : d0_rsp_valid;
    assign m_alu_data1   = sel ? d1_alu_data1   : d0_alu_data1;
    assign m_alu_data2   = sel ? d1_alu_data2   : d0_alu_data2;
    assign m_alu_op      = sel ? d1_alu_op      : d0_alu_op;
    assign m_rsp_result  = sel ? d1_rsp_result  : d0_rsp_result;
    assign m_rsp_zero    = sel ? d1_rsp_zero    : d0_rsp_zero;
    assign m_rsp_lt      = sel ? d1_rsp_lt      : d0_rsp_lt;
    assign m_rsp_gt      = sel ? d1_rsp_gt      : d0_rsp_gt;
    assign m_rsp_taken   = sel ? d1_rsp_taken   : d0_rsp_taken;
    assign m_rsp_illegal = sel ? d1_rsp_illegal : d0_rsp_illegal;

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [3:0]  op;
        logic [31:0] d2;
        logic [31:0] res;
        logic        z;
        logic        lt;
        logic        gt;
        logic        tk;
        logic        ill;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: instruction semantics computed directly from the decode rules.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r;
        logic [31:0] sx, zx;
        r     = v;
        sx    = {{16{v.imm[15]}}, v.imm};
        zx    = {16'h0000, v.imm};
        r.op  = 4'd0;
        r.d2  = v.rt;
        r.ill = 1'b0;
        if (v.opc == 6'h00) begin
            if      (v.fn == 6'h20) r.op = 4'd0;
            else if (v.fn == 6'h22) r.op = 4'd1;
            else if (v.fn == 6'h24) r.op = 4'd2;
            else if (v.fn == 6'h25) r.op = 4'd3;
            else if (v.fn == 6'h2a) r.op = 4'd5;
            else                    r.ill = 1'b1;
        end else if (v.opc == 6'h08 || v.opc == 6'h23 || v.opc == 6'h2b) begin
            r.d2 = sx;
        end else if (v.opc == 6'h0a) begin
            r.op = 4'd5; r.d2 = sx;
        end else if (v.opc == 6'h0c) begin
            r.op = 4'd2; r.d2 = zx;
        end else if (v.opc == 6'h0d) begin
            r.op = 4'd3; r.d2 = zx;
        end else if (v.opc == 6'h04 || v.opc == 6'h05) begin
            r.op = 4'd1;
        end else begin
            r.ill = 1'b1;
        end
        case (r.op)
            4'd1:    r.res = v.rs - r.d2;
            4'd2:    r.res = v.rs & r.d2;
            4'd3:    r.res = v.rs | r.d2;
            4'd5:    r.res = (v.rs < r.d2) ? 32'd1 : 32'd0;
            default: r.res = v.rs + r.d2;
        endcase
        r.z  = (r.res == 32'd0);
        r.lt = v.rs < r.d2;
        r.gt = v.rs > r.d2;
        r.tk = (v.opc == 6'h04) ? r.z : (v.opc == 6'h05) ? !r.z : 1'b0;
        return r;
    endfunction

    task automatic drive_req(input vec_t e);
        req_opcode  = e.opc;
        req_funct   = e.fn;
        req_rs_val  = e.rs;
        req_rt_val  = e.rt;
        req_imm     = e.imm;
        m_req_valid = 1'b1;
    endtask

    task automatic scramble_req();
        req_opcode = 6'($urandom);
        req_funct  = 6'($urandom);
        req_rs_val = $urandom;
        req_rt_val = $urandom;
        req_imm    = 16'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!m_rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag, input vec_t e);
        chk($sformatf("%s result", tag),  m_rsp_result,  e.res);
        chk($sformatf("%s zero", tag),    32'(m_rsp_zero),    32'(e.z));
        chk($sformatf("%s lt", tag),      32'(m_rsp_lt),      32'(e.lt));
        chk($sformatf("%s gt", tag),      32'(m_rsp_gt),      32'(e.gt));
        chk($sformatf("%s taken", tag),   32'(m_rsp_taken),   32'(e.tk));
        chk($sformatf("%s illegal", tag), 32'(m_rsp_illegal), 32'(e.ill));
    endtask

    task automatic run_txn(input vec_t e, input int exp_lat, input string tag);
        int w;
        int lat;
        drive_req(e);
        w = 0;
        while (!m_req_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!m_req_ready) begin
            timeout($sformatf("%s accept", tag));
            m_req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        scramble_req();
        chk($sformatf("%s alu_op", tag),    32'(m_alu_op), 32'(e.op));
        chk($sformatf("%s alu_data1", tag), m_alu_data1, e.rs);
        chk($sformatf("%s alu_data2", tag), m_alu_data2, e.d2);
        wait_rsp(lat);
        if (!m_rsp_valid) begin
            timeout($sformatf("%s rsp_valid", tag));
            return;
        end
        chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s req_ready in resp", tag), 32'(m_req_ready), 32'd0);
        check_rsp(tag, e);
        m_rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_rsp_ready = 1'b0;
        chk($sformatf("%s rsp_valid drop", tag), 32'(m_rsp_valid), 32'd0);
    endtask

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t e2, v;
        int   lat;
        logic [5:0] opcs[12];

        //            opc     fn      rs            rt            imm       op    d2            res           z     lt    gt    tk    ill
        tbl[0]  = '{6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 4'd0, 32'd7,        32'd12,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{6'h04, 6'h00, 32'h1234,     32'h1234,     16'h0000, 4'd1, 32'h1234,     32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{6'h05, 6'h00, 32'h1234,     32'h1234,     16'h0000, 4'd1, 32'h1234,     32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'h08, 6'h00, 32'd3,        32'd0,        16'hFFFF, 4'd0, 32'hFFFFFFFF, 32'd2,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6'h0d, 6'h00, 32'd0,        32'd0,        16'h8000, 4'd3, 32'h00008000, 32'h00008000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'h3f, 6'h00, 32'd1,        32'd1,        16'h0000, 4'd0, 32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{6'h00, 6'h22, 32'd10,       32'd3,        16'h0000, 4'd1, 32'd3,        32'd7,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{6'h00, 6'h24, 32'h0000F0F0, 32'h0000FF00, 16'h0000, 4'd2, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{6'h00, 6'h25, 32'h0F,       32'hF0,       16'h0000, 4'd3, 32'hF0,       32'hFF,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{6'h00, 6'h2a, 32'd2,        32'd9,        16'h0000, 4'd5, 32'd9,        32'd1,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{6'h0a, 6'h00, 32'd5,        32'd0,        16'h0003, 4'd5, 32'd3,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{6'h0c, 6'h00, 32'hFFFFFFFF, 32'd0,        16'h8001, 4'd2, 32'h00008001, 32'h00008001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{6'h23, 6'h00, 32'h100,      32'd0,        16'hFFFC, 4'd0, 32'hFFFFFFFC, 32'hFC,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{6'h2b, 6'h00, 32'h20,       32'd0,        16'h0010, 4'd0, 32'h10,       32'h30,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{6'h00, 6'h00, 32'd4,        32'd6,        16'h0000, 4'd0, 32'd6,        32'd10,       1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{6'h04, 6'h00, 32'd1,        32'd2,        16'h0000, 4'd1, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{6'h05, 6'h00, 32'd1,        32'd2,        16'h0000, 4'd1, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        opcs = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h3f};

        sel = 1'b0;
        m_req_valid = 1'b0;
        m_rsp_ready = 1'b0;
        req_opcode = '0; req_funct = '0; req_rs_val = '0; req_rt_val = '0; req_imm = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset d0 req_ready",   32'(d0_req_ready),   32'd1);
        chk("reset d0 rsp_valid",   32'(d0_rsp_valid),   32'd0);
        chk("reset d0 alu_op",      32'(d0_alu_op),      32'd0);
        chk("reset d0 alu_data1",   d0_alu_data1,        32'd0);
        chk("reset d0 alu_data2",   d0_alu_data2,        32'd0);
        chk("reset d0 rsp_result",  d0_rsp_result,       32'd0);
        chk("reset d0 flags",       {27'd0, d0_rsp_zero, d0_rsp_lt, d0_rsp_gt, d0_rsp_taken, d0_rsp_illegal}, 32'd0);
        chk("reset d1 req_ready",   32'(d1_req_ready),   32'd1);
        chk("reset d1 rsp_valid",   32'(d1_rsp_valid),   32'd0);

        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i], 1, $sformatf("tbl%0d", i));
        end

        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i], 3, $sformatf("x3tbl%0d", i));
        end
        sel = 1'b0;

        // Backpressure: response held 5 cycles while a second request waits.
        drive_req(tbl[0]);
        @(posedge clk); #1;
        e2 = tbl[6];
        drive_req(e2);
        wait_rsp(lat);
        if (!m_rsp_valid) timeout("bp first rsp");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp hold%0d result", c), m_rsp_result, 32'd12);
            chk($sformatf("bp hold%0d valid", c), 32'(m_rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d lt", c), 32'(m_rsp_lt), 32'd1);
            chk($sformatf("bp hold%0d req_ready", c), 32'(m_req_ready), 32'd0);
            chk($sformatf("bp hold%0d alu_data1", c), m_alu_data1, 32'd5);
            @(posedge clk); #1;
        end
        m_rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_rsp_ready = 1'b0;
        chk("bp after hs rsp_valid", 32'(m_rsp_valid), 32'd0);
        chk("bp after hs req_ready", 32'(m_req_ready), 32'd1);
        chk("bp after hs not yet accepted", m_alu_data1, 32'd5);
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        chk("bp second alu_data1", m_alu_data1, e2.rs);
        chk("bp second alu_op", 32'(m_alu_op), 32'(e2.op));
        wait_rsp(lat);
        if (!m_rsp_valid) timeout("bp second rsp");
        check_rsp("bp second", e2);
        m_rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_rsp_ready = 1'b0;

        // Reset while the EXEC_CYCLES=3 instance is mid-execution.
        sel = 1'b1;
        drive_req(tbl[0]);
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        chk("rst-exec accepted", d1_alu_data1, 32'd5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-exec rsp_valid", 32'(d1_rsp_valid), 32'd0);
        chk("rst-exec req_ready", 32'(d1_req_ready), 32'd1);
        chk("rst-exec alu_data1", d1_alu_data1, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst-exec quiet%0d", c), 32'(d1_rsp_valid), 32'd0);
        end
        sel = 1'b0;

        for (int i = 0; i < 40; i++) begin
            v.opc = opcs[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) v.opc = 6'($urandom);
            case ($urandom_range(0, 5))
                0: v.fn = 6'h20;
                1: v.fn = 6'h22;
                2: v.fn = 6'h24;
                3: v.fn = 6'h25;
                4: v.fn = 6'h2a;
                default: v.fn = 6'($urandom);
            endcase
            v.rs  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            v.rt  = ($urandom_range(0, 3) == 0) ? v.rs : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
            v.imm = 16'($urandom);
            v = ref_model(v);
            sel = 1'($urandom_range(0, 1));
            run_txn(v, sel ? 3 : 1, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Requester-side partner of the datapath ALU.
- Accepts a decoded MIPS instruction and its operand values over a valid/ready request channel, then maps opcode/funct to the 4-bit ALU operation code.
- Drives registered data1/data2/aluoperation into the ALU, waits a programmable number of cycles, and captures result/zero/lt/gt.
- Returns result, flags and a branch decision on a valid/ready response channel. Sits between register-read and writeback/PC-select.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_opcode  in  6  instruction bits [31:26].
- req_funct  in  6  instruction bits [5:0]; used only when opcode=000000.
- req_rs_val  in  DATA_W  rs register value.
- req_rt_val  in  DATA_W  rt register value.
- req_imm  in  16  immediate field.
- alu_data1  out  DATA_W  ALU operand 1, registered.
- alu_data2  out  DATA_W  ALU operand 2, registered.
- alu_op  out  4  ALU operation code, registered.
- alu_result  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_lt  in  1  ALU less-than flag.
- alu_gt  in  1  ALU greater-than flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_W  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_lt  out  1  captured lt flag.
- rsp_gt  out  1  captured gt flag.
- rsp_taken  out  1  branch taken; only set for beq/bne.
- rsp_illegal  out  1  unknown opcode/funct; executed as ADD.

Behaviour:
- Reset: state=IDLE; req_ready=1 in the cycle after reset; rsp_valid=0; every other output=0. Reset mid-operation drops the in-flight request and issues no response.
- States:
  - IDLE: req_ready=1. On req_valid, accept at the edge: load alu_* registers and the decode flags, counter=EXEC_CYCLES-1, go to EXEC.
  - EXEC: req_ready=0. If counter==0, capture alu_result/alu_zero/alu_lt/alu_gt into rsp_* at the edge and go to RESP; otherwise decrement the counter.
  - RESP: rsp_valid=1. Hold all rsp_* stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid.
- Timing: with EXEC_CYCLES=1, rsp_valid is high one cycle after the accept edge. Minimum spacing between accepts is EXEC_CYCLES+2 cycles. There is no request/response overlap.
- alu_* hold their last values outside EXEC.
- Op codes: ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0101.
- Decode, with data1=rs in all cases:
  - opcode 000000: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; data2=rt.
  - 001000 addi: ADD, data2=sign-extended imm.
  - 001010 slti: SLT, data2=sign-extended imm.
  - 001100 andi: AND, data2=zero-extended imm.
  - 001101 ori: OR, data2=zero-extended imm.
  - 100011 lw and 101011 sw: ADD, data2=sign-extended imm.
  - 000100 beq: SUB, data2=rt, taken=alu_zero.
  - 000101 bne: SUB, data2=rt, taken=!alu_zero.
  - Any other opcode/funct: ADD, data2=rt, rsp_illegal=1.
- Flags: the ALU leaves lt/gt unchanged when operands are equal. The controller therefore forces rsp_lt=rsp_gt=0 when its registered alu_data1==alu_data2; otherwise rsp_lt/rsp_gt are copied from the ALU. Comparisons are unsigned, as the ALU's are.
- rsp_taken=0 for every non-branch opcode.
- Request fields are sampled only at the accept edge; changes while req_ready=0 are ignored.

Test Plan:
- Reset, then add rs=5 rt=7 (opcode 000000, funct 100000) -> alu_op=0000; one cycle later rsp_valid=1, result=12, zero=0, lt=1, gt=0, taken=0.
- beq rs=rt=0x1234 -> alu_op=0001, result=0, zero=1, taken=1, lt=gt=0 even though the prior response had lt=1. Then bne with the same operands -> taken=0.
- addi rs=3 imm=0xFFFF -> data2=0xFFFFFFFF, result=2. ori rs=0 imm=0x8000 -> data2=0x00008000, result=0x8000.
- Hold rsp_ready=0 for 5 cycles while req_valid=1 with a new request -> rsp_* stable, req_ready=0, second request not accepted until the cycle after the rsp handshake.
- EXEC_CYCLES=3: accept -> rsp_valid rises exactly 3 cycles after the accept edge. Assert rst during EXEC -> next cycle rsp_valid=0, req_ready=1, no response.
- opcode 111111 rs=1 rt=1 -> alu_op=0000, result=2, rsp_illegal=1. A following valid instruction -> rsp_illegal=0.
